// File: rtl/ws2812_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ws2812_stream_decoder
// Description : Recovers 24-bit {R,G,B} pixels and frame boundaries from a
//               WS2812-style single-wire LED data stream.
// Revision    : 1.0 - initial release
// ============================================================================
module ws2812_stream_decoder #(
    parameter int HIGH_MIN     = 5,
    parameter int HIGH_THRESH  = 28,
    parameter int HIGH_MAX     = 60,
    parameter int RESET_CYCLES = 2500,
    parameter int MAX_PIXELS   = 300
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                din,
    output logic [23:0]                         pixel_data,
    output logic                                pixel_valid,
    output logic [$clog2(MAX_PIXELS+1)-1:0]     pixel_index,
    output logic                                frame_done,
    output logic [$clog2(MAX_PIXELS+1)-1:0]     frame_len,
    output logic                                err_pulse,
    output logic [1:0]                          err_code
);

    localparam int HW = $clog2(HIGH_MAX + 1);
    localparam int LW = $clog2(RESET_CYCLES + 1);
    localparam int IW = $clog2(MAX_PIXELS + 1);

    localparam logic [HW-1:0] HMIN   = HW'(HIGH_MIN);
    localparam logic [HW-1:0] HTHR   = HW'(HIGH_THRESH);
    localparam logic [HW-1:0] HMAX   = HW'(HIGH_MAX);
    localparam logic [LW-1:0] LLATCH = LW'(RESET_CYCLES);
    localparam logic [IW-1:0] PMAX   = IW'(MAX_PIXELS);

    localparam logic [1:0] ERR_WIDTH   = 2'b01;
    localparam logic [1:0] ERR_PARTIAL = 2'b10;
    localparam logic [1:0] ERR_OVF     = 2'b11;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        IDLE = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } state_t;

    state_t        state;
    logic          din_m;
    logic          din_s;
    logic [HW-1:0] high_cnt;
    logic [LW-1:0] low_cnt;
    logic [4:0]    bit_cnt;
    logic [22:0]   shift;
    logic [IW-1:0] pix_cnt;
    logic          ovf_seen;

    logic          bit_val;
    logic [23:0]   new_shift;

    assign bit_val   = (high_cnt >= HTHR);
    assign new_shift = {shift, bit_val};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_m <= 1'b0;
            din_s <= 1'b0;
        end else begin
            din_m <= din;
            din_s <= din_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SYNC;
            high_cnt    <= '0;
            low_cnt     <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            pix_cnt     <= '0;
            ovf_seen    <= 1'b0;
            pixel_data  <= '0;
            pixel_valid <= 1'b0;
            pixel_index <= '0;
            frame_done  <= 1'b0;
            frame_len   <= '0;
            err_pulse   <= 1'b0;
            err_code    <= 2'b00;
        end else begin
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            err_pulse   <= 1'b0;

            case (state)
                SYNC: begin
                    if (din_s) begin
                        low_cnt <= '0;
                    end else if (low_cnt == LLATCH) begin
                        low_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        low_cnt <= low_cnt + 1'b1;
                    end
                end

                IDLE: begin
                    // The count includes the cycle in which the rise is seen,
                    // so high_cnt equals the pulse width on falling.
                    if (din_s) begin
                        high_cnt <= HW'(1);
                        state    <= HIGH;
                    end
                end

                HIGH: begin
                    if (high_cnt == HMAX || (!din_s && high_cnt < HMIN)) begin
                        err_pulse <= 1'b1;
                        err_code  <= ERR_WIDTH;
                        bit_cnt   <= '0;
                        pix_cnt   <= '0;
                        ovf_seen  <= 1'b0;
                        low_cnt   <= '0;
                        state     <= SYNC;
                    end else if (!din_s) begin
                        shift   <= new_shift[22:0];
                        low_cnt <= '0;
                        state   <= LOW;
                        if (bit_cnt == 5'd23) begin
                            bit_cnt <= '0;
                            if (pix_cnt < PMAX) begin
                                // Wire order is G,R,B; output order is R,G,B.
                                pixel_data  <= {new_shift[15:8], new_shift[23:16], new_shift[7:0]};
                                pixel_valid <= 1'b1;
                                pixel_index <= pix_cnt;
                                pix_cnt     <= pix_cnt + 1'b1;
                            end else if (!ovf_seen) begin
                                ovf_seen  <= 1'b1;
                                err_pulse <= 1'b1;
                                err_code  <= ERR_OVF;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        high_cnt <= high_cnt + 1'b1;
                    end
                end

                LOW: begin
                    if (low_cnt == LLATCH) begin
                        if (bit_cnt != 5'd0) begin
                            err_pulse <= 1'b1;
                            err_code  <= ERR_PARTIAL;
                        end
                        frame_done <= 1'b1;
                        frame_len  <= pix_cnt;
                        pix_cnt    <= '0;
                        bit_cnt    <= '0;
                        ovf_seen   <= 1'b0;
                        high_cnt   <= HW'(1);
                        state      <= din_s ? HIGH : IDLE;
                    end else if (din_s) begin
                        high_cnt <= HW'(1);
                        state    <= HIGH;
                    end else begin
                        low_cnt <= low_cnt + 1'b1;
                    end
                end

                default: state <= SYNC;
            endcase
        end
    end

endmodule
`default_nettype wire
